// File: rtl/pll_reset_ce_gen.sv
// Reset sequencer and clock-enable generator for the 48 MHz core clock.
// Synchronises PLL lock and an external reset request, holds core reset off until both are clean.
module pll_reset_ce_gen #(
  parameter int unsigned HOLD_CYCLES = 4096,
  parameter int unsigned DIV_1M      = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       ext_reset,
  output logic       core_reset,
  output logic       running,
  output logic       ce_24,
  output logic       ce_12,
  output logic       ce_6,
  output logic       ce_1m,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned HOLD_W = 16;
  localparam int unsigned PH_W   = 6;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DIV_1M - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic lk_meta_q, lk_meta_d, lk_s_q, lk_s_d;
  logic er_meta_q, er_meta_d, er_s_q, er_s_d;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [7:0]        lock_loss_q, lock_loss_d;

  logic core_reset_q, core_reset_d;
  logic running_q, running_d;
  logic ce_24_q, ce_24_d, ce_12_q, ce_12_d, ce_6_q, ce_6_d, ce_1m_q, ce_1m_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    lk_meta_d = pll_locked;
    lk_s_d    = lk_meta_q;
    er_meta_d = ext_reset;
    er_s_d    = er_meta_q;
  end

  // Lock loss outranks the external request in every state.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    lock_loss_d = lock_loss_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lk_s_q && !er_s_q) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      S_HOLD: begin
        if (!lk_s_q) begin
          state_d     = S_WAIT_LOCK;
          hold_d      = '0;
          lock_loss_d = sat_inc8(lock_loss_q);
        end else if (er_s_q) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lk_s_q) begin
          state_d     = S_WAIT_LOCK;
          hold_d      = '0;
          lock_loss_d = sat_inc8(lock_loss_q);
        end else if (er_s_q) begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        hold_d  = '0;
      end
    endcase
  end

  // Phase counter free-runs through HOLD so downstream synchronous resets see enables.
  always_comb begin
    phase_d = '0;
    if ((state_q != S_WAIT_LOCK) && (state_d != S_WAIT_LOCK)) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
    ce_24_d      = (state_d != S_WAIT_LOCK) && phase_q[0];
    ce_12_d      = (state_d != S_WAIT_LOCK) && (phase_q[1:0] == 2'b11);
    ce_6_d       = (state_d != S_WAIT_LOCK) && (phase_q[2:0] == 3'b111);
    ce_1m_d      = (state_d != S_WAIT_LOCK) && (phase_q == PH_LAST);
    core_reset_d = (state_d != S_RUN);
    running_d    = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q    <= 1'b0;
      lk_s_q       <= 1'b0;
      er_meta_q    <= 1'b0;
      er_s_q       <= 1'b0;
      state_q      <= S_WAIT_LOCK;
      hold_q       <= '0;
      phase_q      <= '0;
      lock_loss_q  <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      ce_24_q      <= 1'b0;
      ce_12_q      <= 1'b0;
      ce_6_q       <= 1'b0;
      ce_1m_q      <= 1'b0;
    end else begin
      lk_meta_q    <= lk_meta_d;
      lk_s_q       <= lk_s_d;
      er_meta_q    <= er_meta_d;
      er_s_q       <= er_s_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      phase_q      <= phase_d;
      lock_loss_q  <= lock_loss_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      ce_24_q      <= ce_24_d;
      ce_12_q      <= ce_12_d;
      ce_6_q       <= ce_6_d;
      ce_1m_q      <= ce_1m_d;
    end
  end

  assign core_reset    = core_reset_q;
  assign running       = running_q;
  assign ce_24         = ce_24_q;
  assign ce_12         = ce_12_q;
  assign ce_6          = ce_6_q;
  assign ce_1m         = ce_1m_q;
  assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Scoreboard bench for pll_reset_ce_gen: an edge-level reference model queues expected outputs,
// a negedge monitor compares them, and directed measurements cover latencies and pulse counts.
module tb_pll_reset_ce_gen;

  localparam int HOLD = 16;
  localparam int DIV  = 48;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       ext_reset = 1'b0;
  logic       core_reset, running, ce_24, ce_12, ce_6, ce_1m;
  logic [7:0] lock_loss_cnt;

  pll_reset_ce_gen #(
    .HOLD_CYCLES(HOLD),
    .DIV_1M     (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .ext_reset    (ext_reset),
    .core_reset   (core_reset),
    .running      (running),
    .ce_24        (ce_24),
    .ce_12        (ce_12),
    .ce_6         (ce_6),
    .ce_1m        (ce_1m),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       core_reset;
    logic       running;
    logic       ce_24;
    logic       ce_12;
    logic       ce_6;
    logic       ce_1m;
    logic [7:0] loss;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode 0 = waiting for lock, 1 = holding, 2 = running.
  int m_mode = 0, m_clean = 0, m_ticks = 0, m_loss = 0;
  bit m_lk_m = 0, m_lk_s = 0, m_er_m = 0, m_er_s = 0;

  always @(posedge clk) begin
    obs_t e;
    bit   lk, er;
    int   old_mode, p;
    if (!rst_n) begin
      m_mode = 0; m_clean = 0; m_ticks = 0; m_loss = 0;
      m_lk_m = 0; m_lk_s = 0; m_er_m = 0; m_er_s = 0;
      e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    end else begin
      lk = m_lk_s; er = m_er_s;
      m_lk_s = m_lk_m; m_lk_m = pll_locked;
      m_er_s = m_er_m; m_er_m = ext_reset;
      old_mode = m_mode;
      if (m_mode != 0 && !lk) begin
        m_mode = 0;
        if (m_loss < 255) m_loss++;
      end else if (m_mode == 0) begin
        if (lk && !er) begin m_mode = 1; m_clean = 0; end
      end else if (er) begin
        m_mode = 1; m_clean = 0;
      end else if (m_mode == 1) begin
        m_clean++;
        if (m_clean == HOLD) m_mode = 2;
      end
      p = m_ticks % DIV;
      e.ce_24 = (m_mode != 0) && (p % 2 == 1);
      e.ce_12 = (m_mode != 0) && (p % 4 == 3);
      e.ce_6  = (m_mode != 0) && (p % 8 == 7);
      e.ce_1m = (m_mode != 0) && (p == DIV - 1);
      m_ticks = (m_mode == 0 || old_mode == 0) ? 0 : m_ticks + 1;
      e.core_reset = (m_mode != 2);
      e.running    = (m_mode == 2);
      e.loss       = m_loss[7:0];
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t a, e;
    a = {core_reset, running, ce_24, ce_12, ce_6, ce_1m, lock_loss_cnt};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL cycle_obs t=%0t: no expectation queued, actual=%h", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_obs t=%0t: actual {rst,run,24,12,6,1m,loss}=%b_%b_%b_%b_%b_%b_%0d required=%b_%b_%b_%b_%b_%b_%0d",
                 $time, a.core_reset, a.running, a.ce_24, a.ce_12, a.ce_6, a.ce_1m, a.loss,
                 e.core_reset, e.running, e.ce_24, e.ce_12, e.ce_6, e.ce_1m, e.loss);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int ce_sum();
    return int'(ce_24) + int'(ce_12) + int'(ce_6) + int'(ce_1m);
  endfunction

  // Counts edges (first is the edge just after the call) until core_reset falls after being high.
  task automatic wait_release(output int k);
    bit seen;
    seen = core_reset;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (core_reset) seen = 1;
      else if (seen) begin k = i; break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual %0d compared, required completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n24, n12, n6, n1m, ncoin, nwide, first1m, second1m, loss0, nhigh;
    int lk_hold, er_hold;

    repeat (5) @(negedge clk);
    check("reset_core_reset", core_reset, 1);
    check("reset_running", running, 0);
    check("reset_ce", ce_sum(), 0);
    check("reset_loss", lock_loss_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Power-up release latency
    pll_locked = 1'b1;
    wait_release(k);
    check("powerup_release_edges", k, HOLD + 3);
    check("powerup_running", running, 1);

    // Enable cadence over ten 1 MHz periods
    n24 = 0; n12 = 0; n6 = 0; n1m = 0; ncoin = 0; nwide = 0; first1m = -1; second1m = -1;
    @(negedge clk);
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      n24 += int'(ce_24); n12 += int'(ce_12); n6 += int'(ce_6); n1m += int'(ce_1m);
      if (ce_1m && ce_6 && ce_12 && ce_24) ncoin++;
      if (ce_24 && dut.ce_24_d) nwide++;
      if (ce_1m) begin
        if (first1m < 0) first1m = i;
        else if (second1m < 0) second1m = i;
      end
    end
    check("count_ce_1m", n1m, 10);
    check("count_ce_6", n6, 60);
    check("count_ce_12", n12, 120);
    check("count_ce_24", n24, 240);
    check("ce_1m_coincident", ncoin, 10);
    check("ce_24_single_width", nwide, 0);
    check("ce_1m_period", second1m - first1m, DIV);

    // One-cycle lock drop in RUN
    pll_locked = 1'b0;
    @(posedge clk); #1;
    check("drop_edge1_core_reset", core_reset, 0);
    @(negedge clk);
    pll_locked = 1'b1;
    @(posedge clk); #1;
    check("drop_edge2_core_reset", core_reset, 0);
    @(posedge clk); #1;
    check("drop_edge3_core_reset", core_reset, 1);
    check("drop_edge3_ce", ce_sum(), 0);
    k = 0;
    for (int i = 4; i <= 200; i++) begin
      @(posedge clk); #1;
      if (!core_reset) begin k = i - 1; break; end
    end
    check("relock_release_edges", k, HOLD + 3);
    check("drop_loss_cnt", lock_loss_cnt, 1);

    // Ten-cycle external reset in RUN
    repeat (10) @(negedge clk);
    loss0 = lock_loss_cnt;
    ext_reset = 1'b1;
    nhigh = 0; n24 = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      nhigh += int'(core_reset);
      n24   += int'(ce_24);
      if (i == 10) ext_reset = 1'b0;
    end
    // Last request edge restarts the hold, which then needs HOLD clean edges.
    check("ext_reset_high_cycles", nhigh, 10 + HOLD - 1);
    check("ext_reset_ce_24_runs", n24, 30);
    check("ext_reset_loss_same", lock_loss_cnt, loss0);

    // Lock loss and ext_reset arriving together while in HOLD
    ext_reset = 1'b1;
    repeat (2) @(negedge clk);
    ext_reset = 1'b0;
    repeat (5) @(negedge clk);
    check("simul_in_hold", running, 0);
    loss0 = lock_loss_cnt;
    pll_locked = 1'b0;
    ext_reset  = 1'b1;
    repeat (3) @(negedge clk);
    n24 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n24 += ce_sum();
    end
    check("simul_ce_stopped", n24, 0);
    check("simul_loss_inc", lock_loss_cnt, loss0 + 1);
    pll_locked = 1'b1;
    ext_reset  = 1'b0;
    repeat (HOLD + 8) @(negedge clk);
    check("simul_recovered", running, 1);

    // Random lock drops and reset requests
    lk_hold = 0; er_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (lk_hold > 0) begin
        lk_hold--;
        if (lk_hold == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        pll_locked = 1'b0;
        lk_hold = $urandom_range(1, 4);
      end
      if (er_hold > 0) begin
        er_hold--;
        if (er_hold == 0) ext_reset = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        ext_reset = 1'b1;
        er_hold = $urandom_range(1, 20);
      end
    end
    pll_locked = 1'b1;
    ext_reset  = 1'b0;
    repeat (HOLD + 8) @(negedge clk);

    // Saturation of the lock-loss counter
    for (int d = 0; d < 300; d++) begin
      pll_locked = 1'b1;
      repeat (5) @(negedge clk);
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
    end
    pll_locked = 1'b1;
    repeat (8) @(negedge clk);
    check("loss_saturated", lock_loss_cnt, 255);
    check("sat_in_hold", running, 0);

    // Asynchronous reset mid-HOLD
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_core_reset", core_reset, 1);
    check("async_running", running, 0);
    check("async_ce", ce_sum(), 0);
    check("async_loss", lock_loss_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_ce_gen.md
Name: pll_reset_ce_gen

Overview:
- Sits directly downstream of the core PLL; runs on the PLL's 48 MHz output.
- Consumes the PLL's asynchronous lock indicator and an external (HPS/OSD) reset request.
- Produces a clean, held-off core reset plus phase-aligned single-cycle clock enables at 24, 12, 6 and 1 MHz. The rest of the core runs single-clock on clk, qualified by these enables.

Parameters:
- HOLD_CYCLES, 4096: clk cycles core_reset stays asserted after lock/ext reset is clean; range 2..65535.
- DIV_1M, 48: clk cycles per ce_1m period; must be a multiple of 8, range 8..64.

Ports:
- clk  in  1  48 MHz clock from PLL outclk_3.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to clk.
- ext_reset  in  1  reset request, asynchronous, active-high.
- core_reset  out  1  synchronous active-high core reset.
- running  out  1  high while in RUN.
- ce_24  out  1  1-cycle enable, every 2nd clk.
- ce_12  out  1  1-cycle enable, every 4th clk.
- ce_6  out  1  1-cycle enable, every 8th clk.
- ce_1m  out  1  1-cycle enable, every DIV_1M clk.
- lock_loss_cnt  out  8  saturating count of lock drops while in HOLD or RUN.

Behaviour:
Synchronisers
- pll_locked and ext_reset each pass through a 2-flop synchroniser; outputs are lk_s and er_s.
- Synchroniser flops reset to 0.
- No other logic samples the raw inputs.

rst_n asserted (async)
- state=WAIT_LOCK, phase counter=0, hold counter=0.
- core_reset=1, running=0, all ce_*=0, lock_loss_cnt=0.
- Deassertion is taken synchronously on the next clk edge.

State machine (registered, one transition per edge)
- WAIT_LOCK: lk_s=1 and er_s=0 -> HOLD, hold counter=0. Otherwise stay.
- HOLD:
  - lk_s=0 -> WAIT_LOCK; lock_loss_cnt++.
  - else er_s=1 -> stay; hold counter=0.
  - else hold counter==HOLD_CYCLES-1 -> RUN.
  - else hold counter++.
- RUN:
  - lk_s=0 -> WAIT_LOCK; lock_loss_cnt++.
  - else er_s=1 -> HOLD; hold counter=0.
  - Lock loss has priority over ext_reset in every state.
- lock_loss_cnt saturates at 255 and does not wrap.

Outputs
- core_reset is registered as (next_state != RUN).
- running is registered as (next_state == RUN), so it is always the exact complement of core_reset.
- Latency from the first clk edge sampling pll_locked=1 (ext_reset low) to core_reset falling: 2 sync edges + 1 edge into HOLD + HOLD_CYCLES edges = HOLD_CYCLES+3 edges.
- Assertion latency from pll_locked or ext_reset going active to core_reset high: 3 edges.

Clock enables
- A single phase counter runs modulo DIV_1M (0..DIV_1M-1). It is held at 0 in WAIT_LOCK and free-runs in HOLD and RUN, so enables toggle during reset for synchronous-reset logic.
- Entering WAIT_LOCK forces the counter to 0 and all ce_*=0 on the same edge.
- Enables are registered from the counter value:
  - ce_24 = cnt[0]==1
  - ce_12 = cnt[1:0]==3
  - ce_6 = cnt[2:0]==7
  - ce_1m = cnt==DIV_1M-1
- Every ce_1m pulse coincides with ce_6, ce_12 and ce_24 pulses. Since DIV_1M is a multiple of 8, no phase slip occurs at wrap.
- First ce_24 pulse: the 2nd edge after entering HOLD.

Test Plan:
- Power-up, HOLD_CYCLES=16, DIV_1M=48: hold rst_n low for 5 clk, release, raise pll_locked mid-cycle -> core_reset falls and running rises at edge 19 after the first sampling edge; ce_24/ce_12/ce_6/ce_1m periods measure 2/4/8/48 clk, each exactly 1 clk wide.
- Enable alignment in RUN over 480 clk -> 10 ce_1m pulses, each coincident with ce_6, ce_12 and ce_24; 60 ce_6, 120 ce_12, 240 ce_24.
- Lock drop in RUN: deassert pll_locked for 1 clk -> core_reset=1 3 edges later; all ce_*=0 while in WAIT_LOCK; lock_loss_cnt=1; re-lock reproduces the 19-edge release.
- ext_reset pulse of 10 clk in RUN -> core_reset high for the pulse plus 16 HOLD cycles; enables never stop; lock_loss_cnt unchanged.
- Simultaneous: pll_locked falls and ext_reset rises on the same edge while in HOLD -> WAIT_LOCK taken (not HOLD restart); lock_loss_cnt increments.
- Saturation: 300 lock drops -> lock_loss_cnt=255. Assert rst_n mid-HOLD -> all outputs return to reset values immediately, without waiting for a clk edge.
